tartaruga_regfile: RTL and testbench
====================================

# tartaruga_regfile

Parametrised integer register file with an integrated busy-bit scoreboard for the tartaruga core. The decode stage uses it to read operands and to detect RAW/WAW hazards; the writeback stage uses it to retire results. It generalises the fixed 32×32-bit, two-operand register model to configurable width, depth and read-port count, and adds optional same-cycle write-to-read bypass.

## Interface
Parameters:
- XLEN, 32, register data width in bits
- REG_COUNT, 32, number of architectural registers; power of two, at least 2
- NUM_RD, 2, number of independent read ports
- BYPASS, 1, 1 = writeback data and busy-clear are visible on reads in the same cycle; 0 = visible on the next cycle
- ADDR_W, $clog2(REG_COUNT), register address width (derived; do not override)

Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  synchronous active-high reset
- rd_addr_i  in  NUM_RD×ADDR_W  read addresses
- rd_use_i  in  NUM_RD  port p is a real source operand this cycle
- rd_data_o  out  NUM_RD×XLEN  read data
- rd_busy_o  out  NUM_RD  addressed register has a pending write
- dst_addr_i  in  ADDR_W  destination of the instruction in decode
- dst_we_i  in  1  instruction in decode writes dst_addr_i
- hazard_o  out  1  the instruction in decode must stall
- issue_i  in  1  the instruction in decode leaves decode this cycle
- wb_valid_i  in  1  writeback strobe
- wb_addr_i  in  ADDR_W  writeback destination
- wb_data_i  in  XLEN  writeback data

## Operation
- Storage: REG_COUNT×XLEN array and a REG_COUNT busy vector. Register 0 always reads 0 and is never busy; writes to it are discarded.
- Read: rd_data_o[p] = regs[rd_addr_i[p]]. When BYPASS=1 and wb_valid_i && wb_addr_i==rd_addr_i[p] && wb_addr_i!=0, it returns wb_data_i instead.
- rd_busy_o[p] = busy[rd_addr_i[p]], except that it is forced to 0 when BYPASS=1 and the same-cycle writeback matches under the same condition.
- hazard_o = OR over p of (rd_use_i[p] && rd_busy_o[p]), OR (dst_we_i && dst_addr_i!=0 && the effective busy of dst_addr_i). This covers RAW and WAW hazards.
- Issue: issue_i && dst_we_i && dst_addr_i!=0 && !hazard_o sets busy[dst_addr_i] at the clock edge. An issue while hazard_o=1 is ignored and leaves the busy vector unchanged.
- Writeback: wb_valid_i && wb_addr_i!=0 writes regs[wb_addr_i]=wb_data_i and clears busy[wb_addr_i] at the clock edge.
- Same-cycle issue-set and writeback-clear of the same register: the set wins, so busy ends at 1. The issue's own set is never visible to its own reads or to hazard_o in that cycle.
- Writeback to a non-busy register is legal: data is written and busy stays 0.

## Timing
- Read data, rd_busy_o and hazard_o are combinational from the inputs and current state. There is no read latency.
- A write becomes architecturally visible at the edge after wb_valid_i. With BYPASS=1 it is also visible during the wb cycle.
- A busy bit set by issue is visible from the cycle after issue_i.
- Reset: on a rising edge with rst_i=1, every register and every busy bit goes to 0. Issue and writeback in that cycle are ignored. After reset, rd_data_o=0, rd_busy_o=0 and hazard_o=0 for every input.
- rst_i asserted mid-operation discards all pending busy state. Any writeback arriving after reset is treated as a write to a non-busy register.

## Structure
- The shared package holds XLEN and REG_COUNT defaults (REG_COUNT already exists there), reg_addr_t and bus32_t.
- Add a package struct rf_wb_t {valid, addr, data} so that the writeback stage and this block share one type.
- Natural sub-module: tartaruga_scoreboard, which holds the busy vector, the set/clear priority and the hazard computation. The data array and bypass muxes stay in the top module.

## Test plan
- Reset, then read all addresses on both ports: rd_data_o=0, rd_busy_o=0, hazard_o=0.
- Write x5=0xDEADBEEF; the next cycle read x5 on port 1 returns 0xDEADBEEF. Write x0=0x1234: reads of x0 return 0 and x0 is never busy.
- Issue dst x7; the next cycle a read of x7 with rd_use_i=1 gives hazard_o=1. Writeback x7=0x55 in that cycle: with BYPASS=1, hazard_o=0 and data=0x55 in the same cycle; with BYPASS=0, hazard_o=1 in that cycle, then 0 and 0x55 in the next.
- WAW: x3 busy and decode has dst_we_i=1, dst_addr_i=3 → hazard_o=1. Asserting issue_i leaves busy unchanged; only the later writeback clears x3.
- Same-cycle writeback of x9 and issue of dst x9 with x9 not busy: busy[9]=1 afterwards and regs[9] holds the wb data.
- Issue dst x4, assert rst_i for one cycle, then writeback x4=0xAA: busy[4]=0 throughout after reset and x4 reads 0xAA.

Source files
------------

// File: rtl/tartaruga_pkg.sv
// Shared tartaruga core types and default sizing.
package tartaruga_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_COUNT  = 32;
  localparam int unsigned REG_ADDR_W = $clog2(REG_COUNT);

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [31:0]           bus32_t;

  // Writeback beat shared by the writeback stage and the register file.
  typedef struct packed {
    logic            valid;
    reg_addr_t       addr;
    logic [XLEN-1:0] data;
  } rf_wb_t;

endpackage

// File: rtl/tartaruga_scoreboard.sv
// Busy-bit scoreboard: pending-write tracking and RAW/WAW hazard detection.
module tartaruga_scoreboard #(
  parameter int unsigned REG_COUNT = 32,
  parameter int unsigned NUM_RD    = 2,
  parameter int unsigned BYPASS    = 1,
  parameter int unsigned ADDR_W    = $clog2(REG_COUNT)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  input  logic [NUM_RD-1:0]        rd_use_i,
  input  logic [ADDR_W-1:0]        dst_addr_i,
  input  logic                     dst_we_i,
  input  logic                     issue_i,
  input  logic                     wb_valid_i,
  input  logic [ADDR_W-1:0]        wb_addr_i,
  output logic [NUM_RD-1:0]        rd_busy_o,
  output logic                     hazard_o
);

  logic [REG_COUNT-1:0] busy_q;
  logic                 wb_clr;
  logic                 dst_busy;
  logic                 issue_set;
  logic [NUM_RD-1:0]    rd_busy;
  logic                 hazard;

  assign wb_clr = wb_valid_i && (wb_addr_i != '0);

  // Bit 0 is never set, so x0 reads as not busy without a special case.
  always_comb begin
    rd_busy  = '0;
    dst_busy = busy_q[dst_addr_i] &&
               !((BYPASS != 0) && wb_clr && (wb_addr_i == dst_addr_i));
    hazard   = dst_we_i && (dst_addr_i != '0) && dst_busy;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      rd_busy[p] = busy_q[rd_addr_i[p*ADDR_W +: ADDR_W]] &&
                   !((BYPASS != 0) && wb_clr &&
                     (wb_addr_i == rd_addr_i[p*ADDR_W +: ADDR_W]));
      hazard     = hazard | (rd_use_i[p] & rd_busy[p]);
    end
  end

  assign rd_busy_o = rd_busy;
  assign hazard_o  = hazard;
  assign issue_set = issue_i && dst_we_i && (dst_addr_i != '0) && !hazard;

  // Set is applied after clear so a same-cycle issue to the same register wins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else begin
      if (wb_clr)    busy_q[wb_addr_i]  <= 1'b0;
      if (issue_set) busy_q[dst_addr_i] <= 1'b1;
    end
  end

endmodule

// File: rtl/tartaruga_regfile.sv
// Parametrised integer register file with busy-bit scoreboard and optional writeback bypass.
module tartaruga_regfile #(
  parameter int unsigned XLEN      = tartaruga_pkg::XLEN,
  parameter int unsigned REG_COUNT = tartaruga_pkg::REG_COUNT,
  parameter int unsigned NUM_RD    = 2,
  parameter int unsigned BYPASS    = 1,
  parameter int unsigned ADDR_W    = $clog2(REG_COUNT)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  input  logic [NUM_RD-1:0]        rd_use_i,
  output logic [NUM_RD*XLEN-1:0]   rd_data_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic [ADDR_W-1:0]        dst_addr_i,
  input  logic                     dst_we_i,
  output logic                     hazard_o,
  input  logic                     issue_i,
  input  logic                     wb_valid_i,
  input  logic [ADDR_W-1:0]        wb_addr_i,
  input  logic [XLEN-1:0]          wb_data_i
);

  logic [XLEN-1:0]   regs_q [REG_COUNT];
  logic              wb_we;
  logic [ADDR_W-1:0] ra;

  assign wb_we = wb_valid_i && (wb_addr_i != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      regs_q <= '{default: '0};
    end else if (wb_we) begin
      regs_q[wb_addr_i] <= wb_data_i;
    end
  end

  always_comb begin
    rd_data_o = '0;
    ra        = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      ra = rd_addr_i[p*ADDR_W +: ADDR_W];
      if ((BYPASS != 0) && wb_we && (wb_addr_i == ra)) begin
        rd_data_o[p*XLEN +: XLEN] = wb_data_i;
      end else if (ra != '0) begin
        rd_data_o[p*XLEN +: XLEN] = regs_q[ra];
      end
    end
  end

  tartaruga_scoreboard #(
    .REG_COUNT (REG_COUNT),
    .NUM_RD    (NUM_RD),
    .BYPASS    (BYPASS),
    .ADDR_W    (ADDR_W)
  ) u_scoreboard (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rd_addr_i  (rd_addr_i),
    .rd_use_i   (rd_use_i),
    .dst_addr_i (dst_addr_i),
    .dst_we_i   (dst_we_i),
    .issue_i    (issue_i),
    .wb_valid_i (wb_valid_i),
    .wb_addr_i  (wb_addr_i),
    .rd_busy_o  (rd_busy_o),
    .hazard_o   (hazard_o)
  );

endmodule

// File: tb/tb_tartaruga_regfile.sv
// Scoreboard bench for tartaruga_regfile: one BYPASS=1 and one BYPASS=0 instance share stimulus.
module tb_tartaruga_regfile;

  localparam int unsigned XL = 32;
  localparam int unsigned RC = 16;
  localparam int unsigned NR = 2;
  localparam int unsigned AW = 4;

  typedef struct packed {
    logic [NR*XL-1:0] data;
    logic [NR-1:0]    busy;
    logic             haz;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR*AW-1:0] rd_addr;
  logic [NR-1:0]    rd_use;
  logic [AW-1:0]    dst_addr;
  logic             dst_we;
  logic             issue;
  logic             wb_valid;
  logic [AW-1:0]    wb_addr;
  logic [XL-1:0]    wb_data;

  logic [NR*XL-1:0] rdata [2];
  logic [NR-1:0]    rbusy [2];
  logic             haz   [2];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  exp_t q0[$];
  exp_t q1[$];

  // Reference state: index 0 models BYPASS=1, index 1 models BYPASS=0.
  logic [XL-1:0] m_regs [2][RC];
  bit            m_busy [2][RC];

  always #5 clk = ~clk;

  tartaruga_regfile #(
    .XLEN(XL), .REG_COUNT(RC), .NUM_RD(NR), .BYPASS(1)
  ) dut_byp (
    .clk_i(clk), .rst_i(rst), .rd_addr_i(rd_addr), .rd_use_i(rd_use),
    .rd_data_o(rdata[0]), .rd_busy_o(rbusy[0]), .dst_addr_i(dst_addr),
    .dst_we_i(dst_we), .hazard_o(haz[0]), .issue_i(issue),
    .wb_valid_i(wb_valid), .wb_addr_i(wb_addr), .wb_data_i(wb_data)
  );

  tartaruga_regfile #(
    .XLEN(XL), .REG_COUNT(RC), .NUM_RD(NR), .BYPASS(0)
  ) dut_nobyp (
    .clk_i(clk), .rst_i(rst), .rd_addr_i(rd_addr), .rd_use_i(rd_use),
    .rd_data_o(rdata[1]), .rd_busy_o(rbusy[1]), .dst_addr_i(dst_addr),
    .dst_we_i(dst_we), .hazard_o(haz[1]), .issue_i(issue),
    .wb_valid_i(wb_valid), .wb_addr_i(wb_addr), .wb_data_i(wb_data)
  );

  function automatic exp_t model_out(int b);
    exp_t          e;
    bit            byp;
    logic [AW-1:0] a;
    bit            hit;
    byp = (b == 0);
    e   = '0;
    for (int p = 0; p < NR; p++) begin
      a   = rd_addr[p*AW +: AW];
      hit = byp && wb_valid && (wb_addr == a) && (a != 0);
      if (hit)         e.data[p*XL +: XL] = wb_data;
      else if (a != 0) e.data[p*XL +: XL] = m_regs[b][a];
      e.busy[p] = hit ? 1'b0 : m_busy[b][a];
      if (rd_use[p] && e.busy[p]) e.haz = 1'b1;
    end
    if (dst_we && dst_addr != 0 && m_busy[b][dst_addr] &&
        !(byp && wb_valid && wb_addr == dst_addr))
      e.haz = 1'b1;
    return e;
  endfunction

  task automatic model_edge();
    exp_t e [2];
    for (int b = 0; b < 2; b++) e[b] = model_out(b);
    for (int b = 0; b < 2; b++) begin
      if (rst) begin
        for (int r = 0; r < RC; r++) begin
          m_regs[b][r] = '0;
          m_busy[b][r] = 1'b0;
        end
      end else begin
        if (wb_valid && wb_addr != 0) begin
          m_regs[b][wb_addr] = wb_data;
          m_busy[b][wb_addr] = 1'b0;
        end
        if (issue && dst_we && dst_addr != 0 && !e[b].haz)
          m_busy[b][dst_addr] = 1'b1;
      end
    end
  endtask

  task automatic step(input bit r, input int a0, input int a1, input int use_v,
                      input int da, input bit dwe, input bit iss,
                      input bit wbv, input int wba, input logic [XL-1:0] wbd,
                      input bit chk);
    rst      = r;
    rd_addr  = {AW'(a1), AW'(a0)};
    rd_use   = NR'(use_v);
    dst_addr = AW'(da);
    dst_we   = dwe;
    issue    = iss;
    wb_valid = wbv;
    wb_addr  = AW'(wba);
    wb_data  = wbd;
    if (chk) begin
      q0.push_back(model_out(0));
      q1.push_back(model_out(1));
    end
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic cmp(input int b, input exp_t act, input exp_t e);
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL outputs dut%0d cyc=%0d data=%h/%h busy=%b/%b haz=%b/%b (actual/required)",
               b, cyc, act.data, e.data, act.busy, e.busy, act.haz, e.haz);
    end
  endtask

  always @(negedge clk) begin
    if (q0.size() > 0) cmp(0, {rdata[0], rbusy[0], haz[0]}, q0.pop_front());
    if (q1.size() > 0) cmp(1, {rdata[1], rbusy[1], haz[1]}, q1.pop_front());
  end

  initial begin
    #1;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, '0, 0);
    step(1, 3, 4, 3, 5, 1, 1, 1, 6, 32'h1111, 1);
    for (int a = 0; a < RC; a++) step(0, a, RC-1-a, 3, a, 1, 0, 0, 0, '0, 1);
    // x5 write then readback; x0 write discarded
    step(0, 5, 5, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 1);
    step(0, 0, 5, 2, 0, 0, 0, 0, 0, '0, 1);
    step(0, 0, 0, 3, 0, 1, 1, 1, 0, 32'h1234, 1);
    step(0, 0, 0, 3, 0, 1, 1, 0, 0, '0, 1);
    // RAW on x7 resolved by writeback
    step(0, 0, 0, 0, 7, 1, 1, 0, 0, '0, 1);
    step(0, 7, 0, 1, 0, 0, 0, 1, 7, 32'h55, 1);
    step(0, 7, 7, 3, 0, 0, 0, 0, 0, '0, 1);
    // WAW on x3: second issue ignored
    step(0, 0, 0, 0, 3, 1, 1, 0, 0, '0, 1);
    step(0, 3, 0, 0, 3, 1, 1, 0, 0, '0, 1);
    step(0, 3, 3, 3, 0, 0, 0, 1, 3, 32'h33, 1);
    step(0, 3, 3, 3, 3, 1, 0, 0, 0, '0, 1);
    // same-cycle writeback and issue of x9
    step(0, 9, 0, 1, 9, 1, 1, 1, 9, 32'h99, 1);
    step(0, 9, 9, 3, 9, 1, 0, 0, 0, '0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 9, 32'h999, 1);
    // reset discards pending busy on x4
    step(0, 0, 0, 0, 4, 1, 1, 0, 0, '0, 1);
    step(1, 4, 4, 3, 4, 1, 0, 0, 0, '0, 1);
    step(0, 4, 4, 3, 4, 1, 0, 1, 4, 32'hAA, 1);
    step(0, 4, 4, 3, 4, 1, 0, 0, 0, '0, 1);
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 63) == 0,
           $urandom_range(0, RC-1), $urandom_range(0, RC-1),
           $urandom_range(0, 3), $urandom_range(0, RC-1),
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, $urandom_range(0, RC-1),
           $urandom, 1);
    end
    @(negedge clk);
    #1;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("FAIL drain q0=%0d q1=%0d required=0", q0.size(), q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
